// File: rtl/sdram_arbit.sv
// sdram_arbit
// Owns the single SDRAM command/address/data bus. After reset it passes the
// init sequencer's commands straight to the pins until init_end, then hands
// the bus to one of three requesters (auto-refresh, write, read) with fixed
// priority aref > write > read. Every grant is separated from the next by at
// least one NOP cycle spent in ARBIT.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   init_cmd/ba/addr, init_end      init sequencer bus and completion level
//   aref_req/cmd/ba/addr/end        auto-refresh requester
//   wr_req/cmd/ba/addr/end          write requester
//   wr_sdram_en, wr_data            write data and its DQ drive enable
//   rd_req/cmd/ba/addr/end          read requester
//   aref_en, wr_en, rd_en           grant levels (decoded from state)
//   rd_data                         DQ pins passed straight through
//   sdram_cke ... sdram_addr        SDRAM command/address pins
//   sdram_dq                        bidirectional SDRAM data pins
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,

  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,

  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_data,

  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,

  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] rd_data,

  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    INIT,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0] cmd;

  // State register. Reset forces INIT asynchronously, which also drops every
  // grant and releases DQ immediately because those are decoded from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Requests are only looked at in ARBIT, so returning to
  // ARBIT after every end pulse guarantees the one-cycle NOP turnaround.
  // End pulses belonging to a requester that does not hold the bus are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        if (aref_req)    state_nxt = AREF;
        else if (wr_req) state_nxt = WRITE;
        else if (rd_req) state_nxt = READ;
      end
      AREF: begin
        if (aref_end) state_nxt = ARBIT;
      end
      WRITE: begin
        if (wr_end) state_nxt = ARBIT;
      end
      READ: begin
        if (rd_end) state_nxt = ARBIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Bus mux: the owner of the bus drives the pins, ARBIT issues NOP.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = '0;
    sdram_addr = '0;
    case (state)
      INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

  assign aref_en = (state == AREF);
  assign wr_en   = (state == WRITE);
  assign rd_en   = (state == READ);

  // The write module may leave wr_sdram_en high outside its grant; only the
  // WRITE state lets it reach the pins.
  assign sdram_dq = (wr_en && wr_sdram_en) ? wr_data : {DATA_W{1'bz}};
  assign rd_data  = sdram_dq;

endmodule
